// File: rtl/pipelined_subtractor_pkg.sv
// rtl/pipelined_subtractor_pkg.sv - shared sizing, stage-register type and configuration check for pipelined_subtractor
package pipelined_subtractor_pkg;

    localparam int SUB_WIDTH      = 8;
    localparam int SUB_STAGE_BITS = 2;
    localparam int NSTAGE         = SUB_WIDTH / SUB_STAGE_BITS;

    // Operands travel at full width; each stage only reads its own slice of a_hi/b_hi.
    // diff_lo holds the result bits resolved so far.
    typedef struct packed {
        logic                 valid;
        logic [SUB_WIDTH-1:0] a_hi;
        logic [SUB_WIDTH-1:0] b_hi;
        logic [SUB_WIDTH-1:0] diff_lo;
        logic                 borrow;
    } stage_t;

    function automatic bit cfg_ok(input int width, input int stage_bits);
        return (stage_bits > 0) && (width > 0) && ((width % stage_bits) == 0);
    endfunction

endpackage

// File: rtl/pipelined_subtractor_full_subtractor.sv
// rtl/pipelined_subtractor_full_subtractor.sv - one-bit full subtractor cell (d = x - y - bin)
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/pipelined_subtractor.sv
// rtl/pipelined_subtractor.sv - skewed ripple-borrow pipelined subtractor with valid/ready handshake
// Optional build macro PIPELINED_SUBTRACTOR_SAT_EN clamps the result to 0 on borrow.
module pipelined_subtractor
    import pipelined_subtractor_pkg::*;
#(
    parameter int WIDTH      = SUB_WIDTH,
    parameter int STAGE_BITS = SUB_STAGE_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    if (!cfg_ok(WIDTH, STAGE_BITS) || WIDTH != SUB_WIDTH || STAGE_BITS != SUB_STAGE_BITS) begin : g_bad_cfg
        $error("pipelined_subtractor: WIDTH must be a multiple of STAGE_BITS and match the package sizing");
    end

    // st[0] is the entry register, st[NSTAGE] doubles as the output register.
    stage_t st  [0:NSTAGE];
    stage_t nxt [1:NSTAGE];
    logic   advance;

    assign advance   = ~st[NSTAGE].valid | out_ready;
    assign in_ready  = advance;
    assign out_valid = st[NSTAGE].valid;
    assign diff      = st[NSTAGE].diff_lo;
    assign borrow    = st[NSTAGE].borrow;

    for (genvar k = 1; k <= NSTAGE; k++) begin : g_stage
        localparam int LO = (k - 1) * STAGE_BITS;

        logic [STAGE_BITS:0]   bw;
        logic [STAGE_BITS-1:0] d;
        stage_t                s;

        assign bw[0] = (k == 1) ? 1'b0 : st[k-1].borrow;

        for (genvar i = 0; i < STAGE_BITS; i++) begin : g_bit
            full_subtractor u_fs (
                .x    (st[k-1].a_hi[LO+i]),
                .y    (st[k-1].b_hi[LO+i]),
                .bin  (bw[i]),
                .d    (d[i]),
                .bout (bw[i+1])
            );
        end

        always_comb begin
            s                             = st[k-1];
            s.diff_lo[LO +: STAGE_BITS]   = d;
            s.borrow                      = bw[STAGE_BITS];
`ifdef PIPELINED_SUBTRACTOR_SAT_EN
            if (k == NSTAGE && bw[STAGE_BITS]) begin
                s.diff_lo = '0;
            end
`else
`endif
        end

        assign nxt[k] = s;
    end

    // Global stall: every stage moves only when the output slot is free or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= NSTAGE; k++) begin
                st[k] <= '0;
            end
        end else if (advance) begin
            st[0] <= stage_t'{valid: in_valid, a_hi: a, b_hi: b, diff_lo: '0, borrow: 1'b0};
            for (int k = 1; k <= NSTAGE; k++) begin
                st[k] <= nxt[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// tb/tb_pipelined_subtractor.sv - randomized scoreboard bench for pipelined_subtractor
module tb_pipelined_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;

    pipelined_subtractor dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       br;
    } res_t;

    res_t q[$];
    int   fire_cyc[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic res_t model(input logic [7:0] x, input logic [7:0] y);
        res_t r;
        int   v;
        v    = int'(x) - int'(y);
        r.br = (v < 0);
`ifdef PIPELINED_SUBTRACTOR_SAT_EN
        r.d  = (v < 0) ? 8'd0 : 8'(v);
`else
        r.d  = 8'(v);
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs on the falling edge, sample just after, update the scoreboard.
    task automatic cycle(input bit iv, input logic [7:0] ia, input logic [7:0] ib,
                         input bit ordy, output bit acc);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        out_ready = ordy;
        #1;
        cyc++;
        if (out_valid && out_ready) begin
            fire_cyc.push_back(cyc);
            if (q.size() == 0) begin
                check("unexpected_out", 32'd1, 32'd0);
            end else begin
                res_t e = q.pop_front();
                check("diff", 32'(diff), 32'(e.d));
                check("borrow", 32'(borrow), 32'(e.br));
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(model(ia, ib));
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 8'd0, 1'b1, acc);
    endtask

    task automatic single(input logic [7:0] xa, input logic [7:0] xb,
                          input logic [7:0] exp_d, input bit exp_b, input string tag);
        bit acc;
        idle(8);
        cycle(1'b1, xa, xb, 1'b1, acc);
        check({tag, "_accept"}, 32'(acc), 32'd1);
        for (int j = 1; j <= 5; j++) begin
            cycle(1'b0, 8'd0, 8'd0, 1'b1, acc);
            if (j == 4) check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
            if (j == 5) begin
                check({tag, "_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_diff"}, 32'(diff), 32'(exp_d));
                check({tag, "_borrow"}, 32'(borrow), 32'(exp_b));
            end
        end
    endtask

    // Random traffic that obeys the source rule: a refused pair is re-offered unchanged.
    task automatic random_run(input int n, input int ordy_pct);
        bit         acc;
        bit         pend = 1'b0;
        bit         iv;
        logic [7:0] ra = 8'd0;
        logic [7:0] rb = 8'd0;
        for (int i = 0; i < n; i++) begin
            if (!pend) begin
                iv = ($urandom_range(0, 3) != 0);
                ra = 8'($urandom);
                rb = 8'($urandom);
            end else begin
                iv = 1'b1;
            end
            cycle(iv, ra, rb, ($urandom_range(0, 99) < ordy_pct), acc);
            pend = iv && !acc;
        end
    endtask

    initial begin
        bit         acc;
        int         n_acc;
        logic [7:0] pa, pb, d0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'd0;
        b         = 8'd0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        single(8'd200, 8'd55, 8'd145, 1'b0, "basic");
`ifdef PIPELINED_SUBTRACTOR_SAT_EN
        single(8'd3, 8'd5, 8'h00, 1'b1, "wrap");
`else
        single(8'd3, 8'd5, 8'hFE, 1'b1, "wrap");
`endif
`ifdef PIPELINED_SUBTRACTOR_SAT_EN
        single(8'h00, 8'h01, 8'h00, 1'b1, "chain");
`else
        single(8'h00, 8'h01, 8'hFF, 1'b1, "chain");
`endif
        single(8'hFF, 8'hFF, 8'h00, 1'b0, "equal");

        // Back-to-back: ten pairs, one result per cycle in order.
        idle(8);
        fire_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, acc);
            check("b2b_accept", 32'(acc), 32'd1);
        end
        idle(8);
        check("b2b_count", 32'(fire_cyc.size()), 32'd10);
        if (fire_cyc.size() == 10) check("b2b_span", 32'(fire_cyc[9] - fire_cyc[0]), 32'd9);
        check("b2b_drained", 32'(q.size()), 32'd0);

        // Backpressure: fill the pipe with the sink stalled, then hold.
        idle(8);
        n_acc = 0;
        pa    = 8'($urandom);
        pb    = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, pa, pb, 1'b0, acc);
            if (!acc) break;
            n_acc++;
            pa = 8'($urandom);
            pb = 8'($urandom);
        end
        check("bp_fill_count", 32'(n_acc), 32'd5);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        d0 = diff;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, pa, pb, 1'b0, acc);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_diff_hold", 32'(diff), 32'(d0));
        end
        random_run(20, 100);
        idle(8);
        check("bp_drained", 32'(q.size()), 32'd0);

        random_run(300, 70);
        idle(10);
        check("rand_drained", 32'(q.size()), 32'd0);

        // Reset with pairs in flight: outputs clear at once, nothing stale afterwards.
        for (int i = 0; i < 7; i++) cycle(1'b1, 8'($urandom), 8'($urandom), 1'b1, acc);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_borrow", 32'(borrow), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 8'd0, 8'd0, 1'b1, acc);
            check("post_rst_valid", 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
